// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator sequencer
package calc_pkg;
    localparam int W    = 8;
    localparam int ITER = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
        DIV,
        DONE
    } state_e;
endpackage

// File: rtl/calc_seq_if.sv
// rtl/calc_seq_if.sv - request/result bundle between a requester and calc_seq
interface calc_seq_if;
    import calc_pkg::*;

    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           ovf;
    logic           dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, result, ovf, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, ovf, dbz
    );
endinterface

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - add/sub/mul/div sequencer driving an external 8-bit adder
module calc_seq
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    calc_seq_if.slave    cif,
    output logic [W-1:0] adder_a,
    output logic [W-1:0] adder_b,
    output logic         adder_cin,
    input  logic [W-1:0] adder_s,
    input  logic         adder_cout,
    input  logic         adder_ovr
);
    localparam logic [2:0] LAST = 3'(ITER - 1);

    state_e         state;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           sub_r;
    logic [W-1:0]   p;
    logic [W-1:0]   q;
    logic [2:0]     cnt;
    logic [2*W-1:0] result_r;
    logic           ovf_r;
    logic           dbz_r;

    logic [W-1:0]   mul_p;
    logic [W-1:0]   mul_q;
    logic [W-1:0]   div_rs;
    logic           div_ok;
    logic [W-1:0]   div_r;
    logic [W-1:0]   div_q;

    assign cif.busy   = (state != IDLE);
    assign cif.done   = (state == DONE);
    assign cif.result = result_r;
    assign cif.ovf    = ovf_r;
    assign cif.dbz    = dbz_r;

    // p doubles as the product high byte (mul) and the remainder (div)
    assign {mul_p, mul_q} = {adder_cout, adder_s, q[W-1:1]};
    assign div_rs = {p[W-2:0], q[W-1]};
    assign div_ok = p[W-1] | adder_cout;
    assign div_r  = div_ok ? adder_s : div_rs;
    assign div_q  = {q[W-2:0], div_ok};

    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        case (state)
            ADDSUB: begin
                adder_a   = ra;
                adder_b   = sub_r ? ~rb : rb;
                adder_cin = sub_r;
            end
            MUL: begin
                adder_a = p;
                adder_b = q[0] ? ra : '0;
            end
            DIV: begin
                adder_a   = div_rs;
                adder_b   = ~rb;
                adder_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            sub_r    <= 1'b0;
            p        <= '0;
            q        <= '0;
            cnt      <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cif.start) begin
                    ra    <= cif.a;
                    rb    <= cif.b;
                    sub_r <= cif.op[0];
                    p     <= '0;
                    cnt   <= '0;
                    ovf_r <= 1'b0;
                    dbz_r <= 1'b0;
                    case (op_e'(cif.op))
                        OP_ADD, OP_SUB: begin
                            q     <= '0;
                            state <= ADDSUB;
                        end
                        OP_MUL: begin
                            q     <= cif.b;
                            state <= MUL;
                        end
                        default: begin
                            q <= cif.a;
                            if (cif.b == '0) begin
                                result_r <= '1;
                                dbz_r    <= 1'b1;
                                state    <= DONE;
                            end else begin
                                state <= DIV;
                            end
                        end
                    endcase
                end
                ADDSUB: begin
                    result_r <= {{W{1'b0}}, adder_s};
                    ovf_r    <= adder_ovr;
                    state    <= DONE;
                end
                MUL: begin
                    p   <= mul_p;
                    q   <= mul_q;
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        result_r <= {mul_p, mul_q};
                        state    <= DONE;
                    end
                end
                DIV: begin
                    p   <= div_r;
                    q   <= div_q;
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        result_r <= {div_r, div_q};
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - scoreboard bench for calc_seq with a behavioural adder
module tb_calc_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] adder_a, adder_b, adder_s;
    logic       adder_cin, adder_cout, adder_ovr;
    logic [8:0] sum9;
    logic [7:0] low8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
        int          lat;
        longint      t;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    calc_seq_if cif();

    calc_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cif        (cif),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .adder_ovr  (adder_ovr)
    );

    always #5 clk = ~clk;

    assign sum9       = {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};
    assign low8       = {1'b0, adder_a[6:0]} + {1'b0, adder_b[6:0]} + {7'b0, adder_cin};
    assign adder_s    = sum9[7:0];
    assign adder_cout = sum9[8];
    assign adder_ovr  = sum9[8] ^ low8[7];

    task automatic do_op(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        rec_t e, o;
        int sv;
        logic [7:0] t8;
        e.name = name; e.ovf = 1'b0; e.dbz = 1'b0; e.t = 0;
        case (op)
            2'b00: begin
                t8 = a + b; e.res = {8'h00, t8}; e.lat = 2;
                sv = int'($signed(a)) + int'($signed(b));
                e.ovf = (sv > 127) || (sv < -128);
            end
            2'b01: begin
                t8 = a - b; e.res = {8'h00, t8}; e.lat = 2;
                sv = int'($signed(a)) - int'($signed(b));
                e.ovf = (sv > 127) || (sv < -128);
            end
            2'b10: begin
                e.res = {8'h00, a} * {8'h00, b}; e.lat = 9;
            end
            default: begin
                if (b == 8'h00) begin
                    e.res = 16'hFFFF; e.dbz = 1'b1; e.lat = 1;
                end else begin
                    e.res = {a % b, a / b}; e.lat = 9;
                end
            end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        cif.start = 1'b1; cif.op = op; cif.a = a; cif.b = b;
        @(posedge clk);
        #1 cif.start = 1'b0;
        o = e; o.lat = -1; o.res = 'x; o.ovf = 1'bx; o.dbz = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cif.done) begin
                o.lat = k; o.res = cif.result; o.ovf = cif.ovf; o.dbz = cif.dbz; o.t = $time;
                break;
            end
        end
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cif.start = 1'b0; cif.op = 2'b00; cif.a = 8'h00; cif.b = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", cif.busy); end
        checks++; if (cif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cif.done); end
        checks++; if (cif.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", cif.result); end
        checks++; if ({cif.ovf, cif.dbz} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {cif.ovf, cif.dbz}); end
        checks++; if ({adder_a, adder_b, adder_cin} !== 17'h0) begin errors++; $display("FAIL reset_adder got %h want 0", {adder_a, adder_b, adder_cin}); end
        rst_n = 1'b1;
    endtask

    task automatic test_addsub();
        rec_t e, o;
        do_op("add_7f_01", 2'b00, 8'h7F, 8'h01);
        do_op("sub_05_07", 2'b01, 8'h05, 8'h07);
        do_op("sub_80_01", 2'b01, 8'h80, 8'h01);
        do_op("add_ff_01", 2'b00, 8'hFF, 8'h01);
        for (int i = 0; i < 4; i++)
            do_op("addsub_rand", 2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", e.name, o.lat, e.lat); end
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL %s result got %h want %h", e.name, o.res, e.res); end
            checks++; if ({o.ovf, o.dbz} !== {e.ovf, e.dbz}) begin errors++; $display("FAIL %s flags got %b want %b", e.name, {o.ovf, o.dbz}, {e.ovf, e.dbz}); end
        end
    endtask

    task automatic test_mul();
        rec_t e, o;
        do_op("mul_ff_ff", 2'b10, 8'hFF, 8'hFF);
        do_op("mul_0d_0b", 2'b10, 8'h0D, 8'h0B);
        do_op("mul_x_0", 2'b10, 8'hA5, 8'h00);
        for (int i = 0; i < 4; i++)
            do_op("mul_rand", 2'b10, 8'($urandom), 8'($urandom));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", e.name, o.lat, e.lat); end
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL %s result got %h want %h", e.name, o.res, e.res); end
            checks++; if ({o.ovf, o.dbz} !== {e.ovf, e.dbz}) begin errors++; $display("FAIL %s flags got %b want %b", e.name, {o.ovf, o.dbz}, {e.ovf, e.dbz}); end
        end
    endtask

    task automatic test_div();
        rec_t e, o;
        do_op("div_200_7", 2'b11, 8'd200, 8'd7);
        do_op("div_by_0", 2'b11, 8'h37, 8'h00);
        do_op("div_05_09", 2'b11, 8'h05, 8'h09);
        do_op("div_ff_01", 2'b11, 8'hFF, 8'h01);
        for (int i = 0; i < 4; i++)
            do_op("div_rand", 2'b11, 8'($urandom), 8'($urandom_range(1, 255)));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", e.name, o.lat, e.lat); end
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL %s result got %h want %h", e.name, o.res, e.res); end
            checks++; if ({o.ovf, o.dbz} !== {e.ovf, e.dbz}) begin errors++; $display("FAIL %s flags got %b want %b", e.name, {o.ovf, o.dbz}, {e.ovf, e.dbz}); end
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        cif.start = 1'b1; cif.op = 2'b10; cif.a = 8'h33; cif.b = 8'h44;
        @(posedge clk);
        #1 cif.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({cif.busy, cif.done} !== 2'b00) begin errors++; $display("FAIL midreset_busy_done got %b want 00", {cif.busy, cif.done}); end
        checks++; if (cif.result !== 16'h0000) begin errors++; $display("FAIL midreset_result got %h want 0000", cif.result); end
        checks++; if ({cif.ovf, cif.dbz} !== 2'b00) begin errors++; $display("FAIL midreset_flags got %b want 00", {cif.ovf, cif.dbz}); end
        checks++; if ({adder_a, adder_b, adder_cin} !== 17'h0) begin errors++; $display("FAIL midreset_adder got %h want 0", {adder_a, adder_b, adder_cin}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (cif.done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", dones); end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        logic [15:0] first = 'x;
        @(negedge clk);
        cif.start = 1'b1; cif.op = 2'b00; cif.a = 8'h7F; cif.b = 8'h01;
        @(posedge clk);
        #1 cif.op = 2'b10; cif.a = 8'h0D; cif.b = 8'h0B;
        // start stays high across the ADDSUB and DONE edges, dropped before the first IDLE edge
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (cif.done) begin
                dones++;
                if (dones == 1) first = cif.result;
            end else if (k > 0) begin
                cif.start = 1'b0;
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_dones got %0d want 1", dones); end
        checks++; if (first !== 16'h0080) begin errors++; $display("FAIL busy_start_first got %h want 0080", first); end
        checks++; if (cif.result !== 16'h0080) begin errors++; $display("FAIL busy_start_held got %h want 0080", cif.result); end
        checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", cif.busy); end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        longint tprev = 0;
        longint want;
        do_op("b2b_add0", 2'b00, 8'h10, 8'h20);
        do_op("b2b_add1", 2'b01, 8'h10, 8'h20);
        do_op("b2b_mul", 2'b10, 8'h12, 8'h34);
        do_op("b2b_div", 2'b11, 8'h99, 8'h05);
        do_op("b2b_sub", 2'b01, 8'h00, 8'h01);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL %s result got %h want %h", e.name, o.res, e.res); end
            if (i > 0) begin
                want = 10 * (e.lat + 1);
                checks++; if (o.t - tprev !== want) begin errors++; $display("FAIL %s spacing got %0d want %0d", e.name, o.t - tprev, want); end
            end
            tprev = o.t;
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_reset_mid();
        test_div();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_seq.md
# calc_seq

Operation sequencer for the 8-bit four-function calculator; sits directly upstream of the 8-bit carry-lookahead adder (two chained 4-bit group CLA slices) and consumes its sum. Accepts one operation (add, sub, mul, div) with two 8-bit operands, drives the adder each cycle, and iterates through it for shift-add multiply and restoring divide. Publishes a 16-bit result with a one-cycle done pulse.

## Interface
- W, 8, operand width; fixed at 8 for this release.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  2'b00 add, 2'b01 sub, 2'b10 mul, 2'b11 div.
- a  in  W  operand A (dividend, multiplicand).
- b  in  W  operand B (divisor, multiplier).
- adder_a  out  W  adder operand A.
- adder_b  out  W  adder operand B, already inverted for subtraction.
- adder_cin  out  1  adder carry-in.
- adder_s  in  W  adder sum.
- adder_cout  in  1  adder carry-out of bit 7.
- adder_ovr  in  1  adder signed overflow (C8 ^ C7).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  2W  operation result; held until the next accepted start.
- ovf  out  1  signed overflow (add/sub only); held with result.
- dbz  out  1  divide by zero; held with result.

## Operation
- States: IDLE, ADDSUB, MUL, DIV, DONE.
- IDLE: on start=1, latch a, b and op, clear the iteration counter, then go to ADDSUB (op 00/01), MUL (10) or DIV (11).
- DIV with latched b==0 goes straight to DONE: result=16'hFFFF, dbz=1.
- ADDSUB: adder_a=A, adder_b=B (add) or ~B (sub), adder_cin=op[0].
  - Register result={8'h00, adder_s} and ovf=adder_ovr, then go to DONE.
- MUL, unsigned shift-add, 8 iterations; registers P (8b, reset 0) and Q (multiplier).
  - adder_a=P, adder_b = Q[0] ? A : 8'h00, adder_cin=0.
  - Each cycle {P,Q} <= {adder_cout, adder_s, Q[7:1]}.
  - After the 8th iteration result={P,Q}, ovf=0.
- DIV, unsigned restoring, 8 iterations; registers R (remainder, 0) and Q (dividend).
  - Shift: {r8, Rs} = {R, Q[7]}; adder_a=Rs, adder_b=~B, adder_cin=1.
  - ok = r8 | adder_cout.
  - R <= ok ? adder_s : Rs; Q <= {Q[6:0], ok}.
  - After the 8th iteration result={R, Q} (remainder high byte, quotient low byte), ovf=0, dbz=0.
- DONE: done=1 for exactly one cycle, then return to IDLE. ovf and dbz are cleared when the next start is accepted.
- start while busy (including DONE) is ignored; it is not queued.
- Outside ADDSUB/MUL/DIV, adder outputs are driven to 0 with cin=0.

## Timing
- start sampled at edge N.
- add/sub: compute during cycle N+1; done high during cycle N+2.
- mul/div: iterations during cycles N+1..N+8; done high during cycle N+9.
- Divide by zero: done high during cycle N+1.
- busy rises after edge N and falls after the edge that ends the done cycle.
- Next start is accepted at the edge that ends the done cycle plus one, i.e. back-to-back every 3 (add/sub) or 10 (mul/div) cycles.
- Adder path is combinational within one cycle; its result is registered at the same edge.
- Reset values: state IDLE, busy 0, done 0, result 16'h0000, ovf 0, dbz 0, internal registers 0.
- Reset mid-operation aborts immediately to these values. No done pulse follows.

## Structure
- Shared package calc_pkg holds:
  - W = 8.
  - op_e enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_e enum: IDLE, ADDSUB, MUL, DIV, DONE.
  - ITER = 8.
- The 8-bit adder (two CLA slices, carry-out from the upper group's Gout/Pout) is instantiated beside this block at calculator top, not inside it.
- Single module, no sub-modules. The 3-bit iteration counter and datapath registers are inline.

## Test plan
- add a=8'h7F, b=8'h01, start at N → done during N+2; result=16'h0080, ovf=1.
- sub a=8'h05, b=8'h07 → result=16'h00FE, ovf=0, done during N+2.
- mul a=8'hFF, b=8'hFF → result=16'hFE01, done during N+9.
- mul 8'h0D×8'h0B → 16'h008F.
- div a=8'd200, b=8'd7 → result=16'h041C (q=28, r=4), done during N+9.
- div b=0 → result=16'hFFFF, dbz=1, done during N+1.
- div 8'h05/8'h09 → 16'h0500.
- Assert rst_n=0 at N+4 of a mul → all outputs at reset values, no done pulse.
- start pulsed during busy → ignored; the first result is unchanged and only one done is seen.
